// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU among N_REQ requesters. Round-robin
//   arbitration picks one pending request, latches its operands and op code
//   onto the ALU inputs, captures the ALU result and returns it to the winner
//   with a one-cycle done pulse. Op codes above 9 are rejected with err.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req[N_REQ]          per-requester request level, held until its done bit
//   op/a/b              packed per-requester op code (4b) and operands (WIDTH)
//   alu_a/alu_b         operands driven to the ALU
//   ALUControl          ALU select code
//   alu_q               ALU result (combinational from the outputs above)
//   grant               one-hot owner of the current operation, 0 when idle
//   done                one-hot one-cycle completion pulse
//   result              registered result, valid with done, held otherwise
//   err                 set with done when the granted op code was invalid
module alu_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [4*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] a,
  input  logic [WIDTH*N_REQ-1:0] b,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [3:0]             ALUControl,
  input  logic [WIDTH-1:0]       alu_q,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       result,
  output logic                   err
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state, state_n;
  logic [IW-1:0]      ptr, ptr_n;
  logic [IW-1:0]      gidx, gidx_n;
  logic [N_REQ-1:0]   grant_n, done_n;
  logic [WIDTH-1:0]   result_n, alu_a_n, alu_b_n;
  logic [3:0]         ctl_n;
  logic               err_n;

  // Winner selection: first set req bit scanning upward from ptr, wrapping.
  logic               found;
  logic [IW-1:0]      widx;
  int unsigned        scan_j;
  logic [3:0]         wop;
  logic [WIDTH-1:0]   wa, wb;
  logic [N_REQ-1:0]   wonehot;

  always_comb begin
    found  = 1'b0;
    widx   = '0;
    scan_j = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      scan_j = 32'(ptr) + i;
      if (scan_j >= N_REQ) scan_j = scan_j - N_REQ;
      if (!found && req[scan_j]) begin
        found = 1'b1;
        widx  = IW'(scan_j);
      end
    end
  end

  assign wop     = op[4*widx +: 4];
  assign wa      = a[WIDTH*widx +: WIDTH];
  assign wb      = b[WIDTH*widx +: WIDTH];
  assign wonehot = {{(N_REQ-1){1'b0}}, 1'b1} << widx;

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    gidx_n   = gidx;
    grant_n  = grant;
    done_n   = done;
    result_n = result;
    err_n    = err;
    ctl_n    = ALUControl;
    alu_a_n  = alu_a;
    alu_b_n  = alu_b;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n = wonehot;
          gidx_n  = widx;
          alu_a_n = wa;
          alu_b_n = wb;
          if (wop <= 4'd9) begin
            ctl_n   = wop;
            state_n = EXEC;
          end else begin
            // Invalid code skips the ALU: completion is reported directly.
            ctl_n    = '0;
            result_n = '0;
            err_n    = 1'b1;
            done_n   = wonehot;
            state_n  = DONE;
          end
        end
      end
      EXEC: begin
        result_n = alu_q;
        done_n   = grant;
        err_n    = 1'b0;
        state_n  = DONE;
      end
      DONE: begin
        done_n  = '0;
        err_n   = 1'b0;
        grant_n = '0;
        ctl_n   = '0;
        alu_a_n = '0;
        alu_b_n = '0;
        ptr_n   = (gidx == IW'(N_REQ-1)) ? '0 : gidx + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      grant      <= '0;
      done       <= '0;
      result     <= '0;
      err        <= 1'b0;
      ALUControl <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gidx       <= gidx_n;
      grant      <= grant_n;
      done       <= done_n;
      result     <= result_n;
      err        <= err_n;
      ALUControl <= ctl_n;
      alu_a      <= alu_a_n;
      alu_b      <= alu_b_n;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed requests, scoreboard of expected
// completions checked by an independent monitor on each done pulse.
module tb_alu_share_arbiter;

  localparam int N = 4;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [4*N-1:0] op  = '0;
  logic [W*N-1:0] a   = '0;
  logic [W*N-1:0] b   = '0;
  logic [W-1:0]   alu_a, alu_b, alu_q, result;
  logic [3:0]     ALUControl;
  logic [N-1:0]   grant, done;
  logic           err;

  alu_share_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
    .alu_a(alu_a), .alu_b(alu_b), .ALUControl(ALUControl), .alu_q(alu_q),
    .grant(grant), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  // Reference ALU: constant 10-way mux on the select code.
  always_comb begin
    case (ALUControl)
      4'd0: alu_q = 5'b10000;
      4'd1: alu_q = 5'b10001;
      4'd2: alu_q = 5'b00100;
      4'd3: alu_q = 5'b00010;
      4'd4: alu_q = 5'b00001;
      4'd5: alu_q = 5'b01010;
      4'd6: alu_q = 5'b01111;
      4'd7: alu_q = 5'b01010;
      4'd8: alu_q = 5'b00011;
      4'd9: alu_q = 5'b01000;
      default: alu_q = 5'b00000;
    endcase
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [4:0] res;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    tests++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req_v, $time);
    end
  endtask

  task automatic push(input int idx, input logic [4:0] res, input logic e);
    exp_t x;
    x.idx = idx; x.res = res; x.err = e;
    exp_q.push_back(x);
  endtask

  // Monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (!rst && done != '0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=%b expected none", done);
      end else begin
        exp_t e;
        logic [N-1:0] oh;
        e  = exp_q.pop_front();
        oh = '0;
        oh[e.idx] = 1'b1;
        chk("sb_done", 32'(done), 32'(oh));
        chk("sb_result", 32'(result), 32'(e.res));
        chk("sb_err", 32'(err), 32'(e.err));
      end
    end
  end

  task automatic set_req(input int idx, input logic [3:0] opc, input logic [4:0] av, input logic [4:0] bv);
    op[4*idx +: 4] = opc;
    a[W*idx +: W]  = av;
    b[W*idx +: W]  = bv;
    req[idx]       = 1'b1;
  endtask

  // Waits (bounded) for done[idx] at a negedge, then withdraws the request.
  task automatic wait_done(input int idx, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done[idx]) got = 1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL timeout_done%0d: got no done expected done within 20 cycles", idx);
    end
    req[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, nd, last;

    // 1. Reset held with all requests pending.
    req = 4'b1111;
    repeat (3) begin
      @(negedge clk);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_ctl", 32'(ALUControl), 0);
      chk("rst_ab", 32'({alu_a, alu_b}), 0);
    end
    rst = 1'b0;
    push(0, 5'b10000, 1'b0);
    @(negedge clk);
    chk("first_grant", 32'(grant), 32'b0001);
    req = 4'b0001;
    wait_done(0, lat);
    chk("lat_first", lat, 1);

    // 2. Single request from requester 2, op 1.
    @(negedge clk);
    chk("idle_grant", 32'(grant), 0);
    chk("idle_ctl", 32'(ALUControl), 0);
    set_req(2, 4'd1, 5'd3, 5'd7);
    push(2, 5'b10001, 1'b0);
    @(negedge clk);
    chk("exec_ctl", 32'(ALUControl), 1);
    chk("exec_grant", 32'(grant), 32'b0100);
    chk("exec_a", 32'(alu_a), 3);
    chk("exec_b", 32'(alu_b), 7);
    wait_done(2, lat);
    chk("lat_single", lat, 1);

    // 3. Round-robin with all four requesting continuously (ptr reset to 0).
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 4'd0, 5'd1, 5'd1);
    set_req(1, 4'd3, 5'd2, 5'd2);
    set_req(2, 4'd9, 5'd4, 5'd4);
    set_req(3, 4'd1, 5'd8, 5'd8);
    push(0, 5'b10000, 1'b0);
    push(1, 5'b00010, 1'b0);
    push(2, 5'b01000, 1'b0);
    push(3, 5'b10001, 1'b0);
    push(0, 5'b10000, 1'b0);
    nd = 0;
    last = 0;
    for (int k = 0; k < 40 && nd < 5; k++) begin
      @(negedge clk);
      if (done != '0) begin
        if (nd > 0) chk("rr_spacing", 32'(cyc - last), 3);
        last = cyc;
        nd++;
      end
    end
    chk("rr_count", nd, 5);
    req = '0;

    // 4. Invalid op code from requester 1.
    @(negedge clk);
    set_req(1, 4'b1100, 5'd5, 5'd6);
    push(1, 5'b00000, 1'b1);
    wait_done(1, lat);
    chk("lat_invalid", lat, 1);
    chk("invalid_ctl", 32'(ALUControl), 0);

    // 5. Reset during EXEC drops the operation.
    @(negedge clk);
    set_req(3, 4'd9, 5'd1, 5'd2);
    @(negedge clk);
    chk("pre_rst_grant", 32'(grant), 32'b1000);
    chk("pre_rst_ctl", 32'(ALUControl), 9);
    #2 rst = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 0);
    chk("async_ctl", 32'(ALUControl), 0);
    chk("async_done", 32'(done), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 0);
    end
    rst = 1'b0;
    push(3, 5'b01000, 1'b0);
    wait_done(3, lat);
    chk("lat_rerequest", lat, 2);

    // 6. Op change after grant is ignored.
    @(negedge clk);
    set_req(0, 4'd3, 5'd9, 5'd10);
    push(0, 5'b00010, 1'b0);
    @(negedge clk);
    op[3:0] = 4'd9;
    a[4:0]  = 5'd0;
    chk("latched_ctl", 32'(ALUControl), 3);
    wait_done(0, lat);
    chk("lat_latched", lat, 1);

    repeat (4) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
